// File: rtl/cdb_arbiter_if.sv
// Result-producer handshake and Common Data Bus broadcast signals for cdb_arbiter.
// Each req_* vector packs one field per requester, requester i at slice i.
interface cdb_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 3
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_value;
    logic [NUM_REQ*5-1:0]          req_dest_reg;

    logic                  cdb_valid;
    logic [TAG_WIDTH-1:0]  cdb_tag;
    logic [DATA_WIDTH-1:0] cdb_value;
    logic [4:0]            cdb_dest_reg;
    logic [SRC_W-1:0]      cdb_src;

    // Producer side: functional units and whatever consumes the CDB.
    modport master (
        output req_valid, req_tag, req_value, req_dest_reg,
        input  req_ready, cdb_valid, cdb_tag, cdb_value, cdb_dest_reg, cdb_src
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_tag, req_value, req_dest_reg,
        output req_ready, cdb_valid, cdb_tag, cdb_value, cdb_dest_reg, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter from per-unit one-entry holding registers onto a registered CDB.
// A granted slot is re-armed on the same edge, so one producer can stream one result per cycle.
module cdb_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);
    localparam int               SRC_W    = $clog2(NUM_REQ);
    localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);
    localparam logic [SRC_W:0]   NREQ_W   = (SRC_W + 1)'(NUM_REQ);

    logic [NUM_REQ-1:0]    hold_vld_p0;
    logic [TAG_WIDTH-1:0]  hold_tag_p0 [NUM_REQ];
    logic [DATA_WIDTH-1:0] hold_val_p0 [NUM_REQ];
    logic [4:0]            hold_dst_p0 [NUM_REQ];
    logic [SRC_W-1:0]      rr_ptr;

    logic                  cdb_vld_p1;
    logic [TAG_WIDTH-1:0]  cdb_tag_p1;
    logic [DATA_WIDTH-1:0] cdb_val_p1;
    logic [4:0]            cdb_dst_p1;
    logic [SRC_W-1:0]      cdb_src_p1;

    logic                  grant_any;
    logic [SRC_W-1:0]      grant_idx;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    ready_c;
    logic [NUM_REQ-1:0]    accept;
    logic [SRC_W:0]        scan;
    logic [SRC_W-1:0]      ptr_next;

    // Rotating priority search over occupied holding slots, starting at rr_ptr.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant     = '0;
        scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr} + (SRC_W + 1)'(k);
            if (scan >= NREQ_W) scan = scan - NREQ_W;
            if (!grant_any && hold_vld_p0[scan[SRC_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan[SRC_W-1:0];
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    assign ready_c  = flush ? '0 : (~hold_vld_p0 | grant);
    assign accept   = bus.req_valid & ready_c;
    assign ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + SRC_W'(1);

    // Stage p0: holding registers capture producer results.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                hold_tag_p0[i] <= bus.req_tag[i*TAG_WIDTH +: TAG_WIDTH];
                hold_val_p0[i] <= bus.req_value[i*DATA_WIDTH +: DATA_WIDTH];
                hold_dst_p0[i] <= bus.req_dest_reg[i*5 +: 5];
            end
        end
    end

    // Stage p1: winner moves onto the CDB; flush wins over accept and grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_p0 <= '0;
            rr_ptr      <= '0;
            cdb_vld_p1  <= 1'b0;
            cdb_tag_p1  <= '0;
            cdb_val_p1  <= '0;
            cdb_dst_p1  <= '0;
            cdb_src_p1  <= '0;
        end else if (flush) begin
            hold_vld_p0 <= '0;
            cdb_vld_p1  <= 1'b0;
        end else begin
            hold_vld_p0 <= (hold_vld_p0 & ~grant) | accept;
            cdb_vld_p1  <= grant_any;
            if (grant_any) begin
                rr_ptr     <= ptr_next;
                cdb_tag_p1 <= hold_tag_p0[grant_idx];
                cdb_val_p1 <= hold_val_p0[grant_idx];
                cdb_dst_p1 <= hold_dst_p0[grant_idx];
                cdb_src_p1 <= grant_idx;
            end
        end
    end

    assign bus.req_ready    = ready_c;
    assign bus.cdb_valid    = cdb_vld_p1;
    assign bus.cdb_tag      = cdb_tag_p1;
    assign bus.cdb_value    = cdb_val_p1;
    assign bus.cdb_dest_reg = cdb_dst_p1;
    assign bus.cdb_src      = cdb_src_p1;
endmodule
